io_to_axi: RTL and testbench
============================

Name: io_to_axi

Overview:
- Bridges the MicroBlaze-style IO bus into the team's simplified AXI master interface. This is the reverse of the existing AXI-to-IO bridge.
- On the IO side the block is a responder. It accepts strobed IO requests and answers them with io_ready.
- On the AXI side the block is an initiator. Each request becomes one AXI write (wvalid/wready, then bvalid) or one AXI read (arvalid/arready, then rvalid).
- The block lets an external IO-bus master reach the internal AXI fabric, for example the DNA reader and peripherals. A timeout guards against unmapped addresses.

Parameters:
- TIMEOUT_CYCLES, 255: cycles allowed in any AXI phase before the transaction is aborted. 0 disables the timeout. Legal range 0..65535.
- ERR_RDATA, 32'hFFFFFFFF: value returned on io_read_data when a read times out.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low (already decided)
- io_addr_strobe  input  1  one-cycle request strobe
- io_read_strobe  input  1  read request; qualifies io_addr_strobe
- io_write_strobe  input  1  write request; qualifies io_addr_strobe
- io_addr  input  32  request address; valid during the strobe cycle
- io_byte_enable  input  4  write byte lanes; valid during the strobe cycle
- io_write_data  input  32  write data; valid during the strobe cycle
- io_read_data  output  32  read data; valid while io_ready=1
- io_ready  output  1  one-cycle completion pulse
- wvalid  output  1  AXI write request; carries awaddr, wdata and wstrb together
- wready  input  1  AXI write accept
- awaddr  output  32  write address
- wdata  output  32  write data
- wstrb  output  4  write strobes
- bvalid  input  1  write response; one-cycle pulse
- arvalid  output  1  AXI read request
- arready  input  1  read accept
- araddr  output  32  read address
- rvalid  input  1  read response; one-cycle pulse
- rdata  input  32  read data; valid while rvalid=1
- err_clr  input  1  clears the sticky error flags
- timeout_err  output  1  sticky flag: a transaction was aborted by timeout
- overrun_err  output  1  sticky flag: a strobe arrived while the block was busy

Behaviour:
- Reset: state=IDLE. All outputs are 0, including io_read_data, the AXI address/data buses, the flags and the counter.
- FSM states: IDLE, WREQ, WRESP, RREQ, RRESP, DONE.
- IDLE:
  - On io_addr_strobe with io_write_strobe: latch io_addr, io_byte_enable and io_write_data into awaddr, wstrb and wdata, then go to WREQ.
  - On io_addr_strobe with io_read_strobe only: latch io_addr into araddr, then go to RREQ.
  - If both qualifiers are set, the write wins.
  - If neither qualifier is set, the strobe is ignored.
- WREQ: wvalid=1 and awaddr/wdata/wstrb are held stable. The handshake occurs when wvalid&&wready; wvalid drops the next cycle and the state moves to WRESP.
- WRESP: bvalid is sampled only in this state. bvalid=1 moves to DONE.
- RREQ: arvalid=1 and araddr is held stable. arvalid&&arready moves to RRESP.
- RRESP: rvalid=1 captures rdata into io_read_data and moves to DONE.
- DONE: io_ready=1 for exactly one cycle, then IDLE. io_read_data holds its value until the next capture; it is 0 after writes are not required.
- Latency: strobe at cycle 0, valid asserted at cycle 1. With zero-wait responder handshakes and a response one cycle after the handshake, io_ready occurs at cycle 4. The minimum is 4 cycles.
- bvalid or rvalid arriving in any state other than WRESP or RRESP is ignored.
- Timeout:
  - A 16-bit counter resets to 0 on every entry to WREQ, WRESP, RREQ or RRESP, and increments each cycle in those states.
  - When count==TIMEOUT_CYCLES-1 and the phase has not completed: drop wvalid/arvalid, set timeout_err, and go to DONE.
  - A timed-out read loads io_read_data with ERR_RDATA.
  - Completion wins over timeout in the same cycle.
- overrun_err: set when io_addr_strobe=1 in any state other than IDLE. The strobe is discarded and the current transaction is unaffected.
- err_clr clears both flags. A set condition in the same cycle wins over err_clr.
- Reset mid-transaction: all valids drop immediately (asynchronous) and the FSM returns to IDLE. Pending AXI responses are then ignored.
- A strobe in the same cycle as io_ready (DONE) counts as an overrun. The IO master must wait for io_ready before issuing the next request.

Test Plan:
- Write: strobe with addr=32'h0000_0010, be=4'b0011, data=32'hA5A5_1234; wready tied 1; bvalid pulsed one cycle after the handshake -> wvalid high exactly 1 cycle with matching bus values; io_ready at cycle 4; arvalid stays 0.
- Read: strobe to 32'hC200_0004; arready delayed 3 cycles; rvalid with rdata=32'h1234_5678 after a further 2 cycles -> arvalid held 4 cycles with araddr stable; io_ready one cycle after rvalid with io_read_data=32'h1234_5678.
- Read timeout: TIMEOUT_CYCLES=8; arready never asserted -> arvalid drops after 8 cycles; io_ready pulses with io_read_data=32'hFFFFFFFF; timeout_err=1; err_clr then returns timeout_err to 0.
- Overrun plus late response: second strobe during WRESP -> overrun_err=1 and exactly one io_ready. After a timeout, a stray bvalid in IDLE -> no io_ready.
- Simultaneous read and write qualifiers on one strobe -> only a write is issued (wvalid); arvalid never asserts.
- Async reset asserted while in RREQ with arvalid=1 -> arvalid=0 immediately; the next strobe completes normally.

Source files
------------

// File: rtl/io_to_axi.sv
// Bridges MicroBlaze-style IO bus requests onto the simplified AXI master interface.
// One IO request becomes one AXI write or read. A per-phase timeout aborts requests to unmapped addresses.
module io_to_axi #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        io_addr_strobe,
  input  logic        io_read_strobe,
  input  logic        io_write_strobe,
  input  logic [31:0] io_addr,
  input  logic [3:0]  io_byte_enable,
  input  logic [31:0] io_write_data,
  output logic [31:0] io_read_data,
  output logic        io_ready,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] awaddr,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic        bvalid,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  input  logic        rvalid,
  input  logic [31:0] rdata,
  input  logic        err_clr,
  output logic        timeout_err,
  output logic        overrun_err
);

  // Handshakes: a request transfers on any cycle where valid && ready. The
  // valids are decoded from the state register, so they hold until accepted
  // and drop asynchronously with rst_n. bvalid/rvalid are one-cycle pulses
  // and are only looked at in WRESP/RRESP.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WREQ  = 3'd1,
    S_WRESP = 3'd2,
    S_RREQ  = 3'd3,
    S_RRESP = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam bit          LP_TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_cnt;
  logic [31:0] r_awaddr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_araddr;
  logic [31:0] r_rdata;
  logic        r_timeout_err;
  logic        r_overrun_err;

  logic w_to_hit;
  logic w_abort;
  logic w_cap_rdata;
  logic w_latch_w;
  logic w_latch_r;
  logic w_next_phase;
  logic w_in_phase;
  logic w_overrun;

  assign w_to_hit   = LP_TO_EN && (r_cnt == LP_CNT_LAST);
  assign w_in_phase = (r_state == S_WREQ) || (r_state == S_WRESP) ||
                      (r_state == S_RREQ) || (r_state == S_RRESP);
  assign w_next_phase = (w_next == S_WREQ) || (w_next == S_WRESP) ||
                        (w_next == S_RREQ) || (w_next == S_RRESP);
  assign w_overrun  = io_addr_strobe && (r_state != S_IDLE);

  // Completion is tested before the timeout so it wins in the same cycle.
  always_comb begin
    w_next      = r_state;
    w_abort     = 1'b0;
    w_cap_rdata = 1'b0;
    w_latch_w   = 1'b0;
    w_latch_r   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_addr_strobe && io_write_strobe) begin
          w_latch_w = 1'b1;
          w_next    = S_WREQ;
        end else if (io_addr_strobe && io_read_strobe) begin
          w_latch_r = 1'b1;
          w_next    = S_RREQ;
        end
      end
      S_WREQ: begin
        if (wready) begin
          w_next = S_WRESP;
        end else if (w_to_hit) begin
          w_abort = 1'b1;
          w_next  = S_DONE;
        end
      end
      S_WRESP: begin
        if (bvalid) begin
          w_next = S_DONE;
        end else if (w_to_hit) begin
          w_abort = 1'b1;
          w_next  = S_DONE;
        end
      end
      S_RREQ: begin
        if (arready) begin
          w_next = S_RRESP;
        end else if (w_to_hit) begin
          w_abort = 1'b1;
          w_next  = S_DONE;
        end
      end
      S_RRESP: begin
        if (rvalid) begin
          w_cap_rdata = 1'b1;
          w_next      = S_DONE;
        end else if (w_to_hit) begin
          w_abort = 1'b1;
          w_next  = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Phase counter restarts on every entry into a request/response phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_next_phase && (w_next != r_state)) begin
      r_cnt <= '0;
    end else if (w_in_phase) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_araddr <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_latch_w) begin
        r_awaddr <= io_addr;
        r_wdata  <= io_write_data;
        r_wstrb  <= io_byte_enable;
      end
      if (w_latch_r) begin
        r_araddr <= io_addr;
      end
      if (w_cap_rdata) begin
        r_rdata <= rdata;
      end else if (w_abort && ((r_state == S_RREQ) || (r_state == S_RRESP))) begin
        r_rdata <= ERR_RDATA;
      end
    end
  end

  // Sticky flags: a new set event beats err_clr in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timeout_err <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      if (w_abort) begin
        r_timeout_err <= 1'b1;
      end else if (err_clr) begin
        r_timeout_err <= 1'b0;
      end
      if (w_overrun) begin
        r_overrun_err <= 1'b1;
      end else if (err_clr) begin
        r_overrun_err <= 1'b0;
      end
    end
  end

  assign wvalid       = (r_state == S_WREQ);
  assign arvalid      = (r_state == S_RREQ);
  assign io_ready     = (r_state == S_DONE);
  assign awaddr       = r_awaddr;
  assign wdata        = r_wdata;
  assign wstrb        = r_wstrb;
  assign araddr       = r_araddr;
  assign io_read_data = r_rdata;
  assign timeout_err  = r_timeout_err;
  assign overrun_err  = r_overrun_err;

endmodule

// File: tb/tb_io_to_axi.sv
// Directed bench for io_to_axi: writes, reads, timeouts, overrun, dual qualifiers and async reset.
// Runs with TIMEOUT_CYCLES=8 so timeout cases stay short.
module tb_io_to_axi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        io_addr_strobe, io_read_strobe, io_write_strobe;
  logic [31:0] io_addr, io_write_data, io_read_data;
  logic [3:0]  io_byte_enable;
  logic        io_ready;
  logic        wvalid, wready;
  logic [31:0] awaddr, wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err_clr, timeout_err, overrun_err;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  io_to_axi #(.TIMEOUT_CYCLES(8), .ERR_RDATA(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst_n(rst_n),
    .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
    .io_write_strobe(io_write_strobe), .io_addr(io_addr),
    .io_byte_enable(io_byte_enable), .io_write_data(io_write_data),
    .io_read_data(io_read_data), .io_ready(io_ready),
    .wvalid(wvalid), .wready(wready), .awaddr(awaddr), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rdata(rdata),
    .err_clr(err_clr), .timeout_err(timeout_err), .overrun_err(overrun_err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives a one-cycle strobe (cycle 0); returns at cycle 1.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] data);
    io_addr_strobe  = 1'b1;
    io_read_strobe  = rd;
    io_write_strobe = wr;
    io_addr         = addr;
    io_byte_enable  = be;
    io_write_data   = data;
    step();
    io_addr_strobe  = 1'b0;
    io_read_strobe  = 1'b0;
    io_write_strobe = 1'b0;
  endtask

  task automatic check_read(input string tag);
    logic [31:0] exp;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got %h expected <empty queue>", tag, io_read_data);
    end else begin
      exp = exp_q.pop_front();
      check_val(tag, io_read_data, exp);
    end
  endtask

  // Steps until io_ready (bounded); counts cycles where arvalid/wvalid were high.
  task automatic wait_ready(input string tag, input int max_cyc,
                            output int n_ar, output int n_w);
    logic seen;
    seen = 1'b0;
    n_ar = 0;
    n_w  = 0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      if (arvalid) n_ar++;
      if (wvalid)  n_w++;
      if (io_ready) seen = 1'b1;
      else step();
    end
    check_val(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_ar, n_w, n_rdy;
    logic ar_seen;
    rst_n = 1'b0;
    io_addr_strobe = 0; io_read_strobe = 0; io_write_strobe = 0;
    io_addr = '0; io_byte_enable = '0; io_write_data = '0;
    wready = 0; bvalid = 0; arready = 0; rvalid = 0; rdata = '0; err_clr = 0;
    step(); step();
    check_val("rst_buses", awaddr | wdata | araddr | io_read_data | 32'(wstrb), 32'd0);
    check_val("rst_ctrl", 32'({wvalid, arvalid, io_ready, timeout_err, overrun_err}), 32'd0);
    rst_n = 1'b1;
    step();

    // Write, zero-wait accept, bvalid issued the cycle after wvalid drops.
    wready = 1'b1;
    issue(1'b0, 1'b1, 32'h0000_0010, 4'b0011, 32'hA5A5_1234);
    check_val("wr_c1_wvalid", 32'(wvalid), 32'd1);
    check_val("wr_awaddr", awaddr, 32'h0000_0010);
    check_val("wr_wdata", wdata, 32'hA5A5_1234);
    check_val("wr_wstrb", 32'(wstrb), 32'h3);
    check_val("wr_c1_arvalid", 32'(arvalid), 32'd0);
    step();
    check_val("wr_c2_wvalid", 32'(wvalid), 32'd0);
    check_val("wr_c2_ready", 32'(io_ready), 32'd0);
    step();
    check_val("wr_c3_ready", 32'(io_ready), 32'd0);
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    check_val("wr_c4_ready", 32'(io_ready), 32'd1);
    check_val("wr_c4_arvalid", 32'(arvalid), 32'd0);
    step();
    check_val("wr_c5_ready", 32'(io_ready), 32'd0);

    // Read: arready in the 4th arvalid cycle, rvalid two cycles later.
    wready = 1'b0;
    exp_q.push_back(32'h1234_5678);
    issue(1'b1, 1'b0, 32'hC200_0004, 4'h0, 32'h0);
    n_ar = 0;
    for (int i = 0; i < 4; i++) begin
      if (arvalid && araddr == 32'hC200_0004) n_ar++;
      if (i == 3) arready = 1'b1;
      if (i < 3) step();
    end
    step();
    arready = 1'b0;
    check_val("rd_arvalid_cycles", 32'(n_ar), 32'd4);
    check_val("rd_c5_arvalid", 32'(arvalid), 32'd0);
    step();
    rvalid = 1'b1;
    rdata  = 32'h1234_5678;
    step();
    rvalid = 1'b0;
    rdata  = 32'h0;
    check_val("rd_c7_ready", 32'(io_ready), 32'd1);
    check_read("rd_data");
    step();
    check_val("rd_c8_ready", 32'(io_ready), 32'd0);
    check_val("rd_data_hold", io_read_data, 32'h1234_5678);

    // Read timeout with arready never asserted.
    exp_q.push_back(32'hFFFF_FFFF);
    issue(1'b1, 1'b0, 32'h0000_0040, 4'h0, 32'h0);
    wait_ready("rto_ready", 20, n_ar, n_w);
    check_val("rto_arvalid_cycles", 32'(n_ar), 32'd8);
    check_read("rto_data");
    check_val("rto_flag", 32'(timeout_err), 32'd1);
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check_val("rto_flag_clr", 32'(timeout_err), 32'd0);

    // Second strobe during WRESP is an overrun and is discarded.
    wready = 1'b1;
    issue(1'b0, 1'b1, 32'h0000_0020, 4'hF, 32'hDEAD_BEEF);
    step();
    io_addr_strobe = 1'b1; io_read_strobe = 1'b1; io_addr = 32'h0000_0099;
    step();
    io_addr_strobe = 1'b0; io_read_strobe = 1'b0;
    check_val("ovr_flag", 32'(overrun_err), 32'd1);
    check_val("ovr_arvalid", 32'(arvalid), 32'd0);
    check_val("ovr_awaddr", awaddr, 32'h0000_0020);
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    check_val("ovr_ready", 32'(io_ready), 32'd1);
    n_rdy = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (io_ready) n_rdy++;
    end
    check_val("ovr_single_ready", 32'(n_rdy), 32'd0);

    // Write timeout, then a stray bvalid in IDLE must not complete anything.
    wready = 1'b0;
    issue(1'b0, 1'b1, 32'h0000_0030, 4'h1, 32'h0000_0055);
    wait_ready("wto_ready", 20, n_ar, n_w);
    check_val("wto_wvalid_cycles", 32'(n_w), 32'd8);
    check_val("wto_flag", 32'(timeout_err), 32'd1);
    step();
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    n_rdy = 0;
    for (int i = 0; i < 4; i++) begin
      if (io_ready) n_rdy++;
      step();
    end
    check_val("stray_bvalid_ready", 32'(n_rdy), 32'd0);

    // Both qualifiers: the write wins.
    wready = 1'b1;
    issue(1'b1, 1'b1, 32'h0000_0044, 4'hC, 32'h0BAD_F00D);
    check_val("both_wvalid", 32'(wvalid), 32'd1);
    check_val("both_wdata", wdata, 32'h0BAD_F00D);
    ar_seen = arvalid;
    step();
    ar_seen |= arvalid;
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    ar_seen |= arvalid;
    check_val("both_ready", 32'(io_ready), 32'd1);
    step();
    ar_seen |= arvalid;
    check_val("both_no_arvalid", 32'(ar_seen), 32'd0);

    // Async reset while in RREQ drops arvalid without waiting for a clock edge.
    wready = 1'b0;
    issue(1'b1, 1'b0, 32'h0000_0050, 4'h0, 32'h0);
    check_val("arst_pre_arvalid", 32'(arvalid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_arvalid", 32'(arvalid), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    arready = 1'b1;
    exp_q.push_back(32'hCAFE_0001);
    issue(1'b1, 1'b0, 32'hC000_0008, 4'h0, 32'h0);
    check_val("arst_next_araddr", araddr, 32'hC000_0008);
    step();
    arready = 1'b0;
    rvalid = 1'b1;
    rdata  = 32'hCAFE_0001;
    step();
    rvalid = 1'b0;
    check_val("arst_next_ready", 32'(io_ready), 32'd1);
    check_read("arst_next_data");
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
